// File: rtl/ddr3_wb_memtest.sv
// ddr3_wb_memtest: post-init DDR3 self-test master on the LiteDRAM user Wishbone port.
// Writes a deterministic pattern over NUM_WORDS words from BASE_ADDR, reads it back and
// compares, reporting pass/fail, error count and the first failing address.
// Build option: define MEMTEST_LFSR_EN to use a 32-bit Galois LFSR data pattern instead
// of the default address-derived pattern {idx[15:0], ~idx[15:0]}.

module ddr3_wb_memtest #(
    parameter logic [29:0] BASE_ADDR   = 30'h0,
    parameter int unsigned NUM_WORDS   = 1024,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        sys_clk_100mhz,
    input  logic        rst_n,
    input  logic        init_done_i,
    input  logic        start_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [29:0] wb_adr_o,
    output logic [31:0] wb_dat_w_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_r_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] err_count_o,
    output logic [29:0] first_err_addr_o
);

    localparam logic [29:0] LastIdx  = 30'(NUM_WORDS - 1);
    localparam logic [31:0] WdogLast = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrWait,
        StRdReq,
        StRdWait,
        StDone
    } state_e;

    state_e      state_q;
    logic [29:0] idx_q;
    logic [31:0] wdog_q;
    logic        cyc_q;
    logic        we_q;
    logic [29:0] adr_q;
    logic [31:0] dat_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [15:0] err_cnt_q;
    logic [29:0] first_q;

    logic [31:0] pattern;
    logic        in_wait;
    logic        is_wr_wait;
    logic        last_word;
    logic        timeout;
    logic        word_end;
    logic        err_hit;
    logic        aborting;
    logic [15:0] err_cnt_inc;

    // Per-word status decode for the current transfer
    always_comb begin
        is_wr_wait  = (state_q == StWrWait);
        in_wait     = is_wr_wait || (state_q == StRdWait);
        last_word   = (idx_q == LastIdx);
        timeout     = in_wait && !wb_ack_i && !wb_err_i && (wdog_q == WdogLast);
        word_end    = in_wait && (wb_ack_i || wb_err_i || timeout);
        // err wins over a simultaneous ack, so a word is counted at most once
        err_hit     = in_wait && (wb_err_i || timeout ||
                      ((state_q == StRdWait) && wb_ack_i && (wb_dat_r_i != pattern)));
        err_cnt_inc = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
        aborting    = busy_q && !init_done_i;
    end

`ifdef MEMTEST_LFSR_EN
    localparam logic [31:0] LfsrSeed = 32'hACE1_2468;
    localparam logic [31:0] LfsrPoly = 32'h8020_0003;

    logic [31:0] lfsr_q;
    logic        lfsr_load;
    logic        lfsr_adv;

    // Reload at every run start and before the read phase so reads replay the write sequence
    always_comb begin
        lfsr_load = aborting || (state_q == StIdle) || ((state_q == StDone) && start_i) ||
                    (is_wr_wait && word_end && last_word);
        lfsr_adv  = word_end && !aborting;
    end

    // Galois LFSR stepped once per finished word
    always_ff @(posedge sys_clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LfsrSeed;
        end else if (lfsr_load) begin
            lfsr_q <= LfsrSeed;
        end else if (lfsr_adv) begin
            lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrPoly : 32'h0);
        end
    end

    assign pattern = lfsr_q;
`else
    assign pattern = {idx_q[15:0], ~idx_q[15:0]};
`endif

    // Test sequencer with registered bus and status outputs
    always_ff @(posedge sys_clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            wdog_q    <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= '0;
            first_q   <= '0;
        end else if (aborting) begin
            // init lost: drop the bus immediately and wait for init to return
            state_q   <= StIdle;
            idx_q     <= '0;
            wdog_q    <= '0;
            cyc_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_cnt_q <= '0;
            first_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (init_done_i) begin
                        state_q   <= StWrReq;
                        busy_q    <= 1'b1;
                        idx_q     <= '0;
                        err_cnt_q <= '0;
                        first_q   <= '0;
                    end
                end
                StWrReq, StRdReq: begin
                    cyc_q   <= 1'b1;
                    we_q    <= (state_q == StWrReq);
                    adr_q   <= BASE_ADDR + idx_q;
                    dat_q   <= pattern;
                    wdog_q  <= '0;
                    state_q <= (state_q == StWrReq) ? StWrWait : StRdWait;
                end
                StWrWait, StRdWait: begin
                    if (word_end) begin
                        cyc_q <= 1'b0;
                        if (err_hit) begin
                            err_cnt_q <= err_cnt_inc;
                            if (err_cnt_q == 16'd0) begin
                                first_q <= adr_q;
                            end
                        end
                        if (!last_word) begin
                            idx_q   <= idx_q + 30'd1;
                            state_q <= is_wr_wait ? StWrReq : StRdReq;
                        end else if (is_wr_wait) begin
                            idx_q   <= '0;
                            state_q <= StRdReq;
                        end else begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= !err_hit && (err_cnt_q == 16'd0);
                        end
                    end else begin
                        wdog_q <= wdog_q + 32'd1;
                    end
                end
                StDone: begin
                    if (start_i) begin
                        state_q   <= StWrReq;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        err_cnt_q <= '0;
                        first_q   <= '0;
                        idx_q     <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wb_cyc_o         = cyc_q;
    assign wb_stb_o         = cyc_q;
    assign wb_we_o          = we_q;
    assign wb_adr_o         = adr_q;
    assign wb_dat_w_o       = dat_q;
    assign wb_sel_o         = 4'b1111;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_cnt_q;
    assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_ddr3_wb_memtest.sv
// tb_ddr3_wb_memtest: directed runs against a fault-injecting Wishbone slave, with a
// transaction-level model checked every cycle and per-run literal expectations.

module tb_ddr3_wb_memtest;

    localparam logic [29:0] Base = 30'h100;
    localparam int          Nw   = 16;
    localparam int          To   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic        start = 1'b0;
    logic        wb_cyc, wb_stb, wb_we;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_r;
    logic        wb_ack, wb_err;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [29:0] first_err;

    always #5 clk = ~clk;

    ddr3_wb_memtest #(
        .BASE_ADDR  (Base),
        .NUM_WORDS  (Nw),
        .TIMEOUT_CYC(To)
    ) dut (
        .sys_clk_100mhz  (clk),
        .rst_n           (rst_n),
        .init_done_i     (init_done),
        .start_i         (start),
        .wb_cyc_o        (wb_cyc),
        .wb_stb_o        (wb_stb),
        .wb_we_o         (wb_we),
        .wb_adr_o        (wb_adr),
        .wb_dat_w_o      (wb_dat_w),
        .wb_sel_o        (wb_sel),
        .wb_dat_r_i      (wb_dat_r),
        .wb_ack_i        (wb_ack),
        .wb_err_i        (wb_err),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass),
        .err_count_o     (err_count),
        .first_err_addr_o(first_err)
    );

    // Fault tables, indexed by word: write never acked, read answered with err, read bit 0 flipped
    logic [Nw-1:0] f_noack = '0;
    logic [Nw-1:0] f_rderr = '0;
    logic [Nw-1:0] f_flip  = '0;

    // Slave: registered ack/err one cycle after a new request; memory written on the acked cycle
    logic [31:0] mem [Nw];
    logic [3:0]  s_word;
    always_comb s_word = 4'(wb_adr - Base);
    assign wb_dat_r = mem[s_word] ^ {31'd0, f_flip[s_word]};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            for (int i = 0; i < Nw; i++) mem[i] <= 32'h0;
        end else begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            if (wb_cyc && wb_stb && !wb_ack && !wb_err) begin
                if (wb_we && f_noack[s_word]) begin
                    wb_ack <= 1'b0;
                end else if (!wb_we && f_rderr[s_word]) begin
                    wb_err <= 1'b1;
                end else begin
                    wb_ack <= 1'b1;
                end
            end
            if (wb_cyc && wb_stb && wb_ack && wb_we) mem[s_word] <= wb_dat_w;
        end
    end

    function automatic logic [31:0] pat(input logic [29:0] i);
`ifdef MEMTEST_LFSR_EN
        logic [31:0] v;
        v = 32'hACE1_2468;
        for (int k = 0; k < int'(i); k++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
        return v;
`else
        return {i[15:0], ~i[15:0]};
`endif
    endfunction

    // Stimulus-owned controls read by the compare process
    logic        hung = 1'b0;
    logic        lit_on = 1'b0;
    int          lit_errs = 0;
    logic [29:0] lit_first = '0;
    logic        cmp_seq = 1'b0;

    int vec_n = 0;
    int miss_n = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_n++;
        if (act !== exp) begin
            miss_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process state
    int          tx_n = 0;
    int          run_n = 0;
    int          cyc_len = 0;
    int          m_errs = 0;
    logic [29:0] m_first = '0;
    logic        got_resp = 1'b0;
    logic        hung_seen = 1'b0;
    logic        busy_p = 1'b0, cyc_p = 1'b0, done_p = 1'b0, init_p = 1'b0, init_pp = 1'b0;
    logic [29:0] cap_idx, cap_adr;
    logic [31:0] cap_dat;
    logic        cap_we, cap_wr;
    logic [29:0] ref_adr [2*Nw];
    logic [31:0] ref_dat [2*Nw];

    // Per-cycle checks against the transaction-level model
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_cyc", wb_cyc, 0);
            chk("rst_stb", wb_stb, 0);
            chk("rst_we", wb_we, 0);
            chk("rst_adr", wb_adr, 0);
            chk("rst_dat_w", wb_dat_w, 0);
            chk("rst_sel", wb_sel, 4'hF);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_pass", pass, 0);
            chk("rst_err_count", err_count, 0);
            chk("rst_first_err", first_err, 0);
            busy_p = 1'b0; cyc_p = 1'b0; done_p = 1'b0; init_p = 1'b0; init_pp = 1'b0;
        end else begin
            if (hung && !hung_seen) begin
                chk("bench_wait_bound", hung, 0);
                hung_seen = 1'b1;
            end
            chk("cyc_eq_stb", wb_stb, wb_cyc);
            chk("sel_const", wb_sel, 4'hF);
            chk("busy_done_excl", busy && done, 0);
            if (busy && !busy_p) begin
                run_n++;
                tx_n = 0; m_errs = 0; m_first = '0;
                chk("run_clr_err_count", err_count, 0);
                chk("run_clr_first_err", first_err, 0);
                chk("run_clr_done", done, 0);
                chk("run_clr_pass", pass, 0);
            end
            if (init_pp && !init_p && busy_p) begin
                chk("abort_cyc", wb_cyc, 0);
                chk("abort_stb", wb_stb, 0);
                chk("abort_busy", busy, 0);
                chk("abort_err_count", err_count, 0);
            end
            if (wb_cyc && !cyc_p) begin
                cap_idx = 30'(tx_n % Nw);
                cap_we  = (tx_n < Nw);
                cap_adr = wb_adr; cap_dat = wb_dat_w; cap_wr = wb_we;
                cyc_len = 0; got_resp = 1'b0;
                chk("tx_adr", wb_adr, Base + cap_idx);
                chk("tx_we", wb_we, cap_we);
                if (cap_we) chk("tx_wdata", wb_dat_w, pat(cap_idx));
                if (tx_n < 2*Nw) begin
                    if (run_n == 1) begin
                        ref_adr[tx_n] = wb_adr;
                        ref_dat[tx_n] = wb_dat_w;
                    end
                    if (cmp_seq) begin
                        chk("rerun_adr", wb_adr, ref_adr[tx_n]);
                        chk("rerun_dat_w", wb_dat_w, ref_dat[tx_n]);
                    end
                end
            end else if (wb_cyc) begin
                chk("hold_stable", {wb_adr, wb_dat_w, wb_we}, {cap_adr, cap_dat, cap_wr});
            end
            if (wb_cyc) begin
                cyc_len++;
                if ((wb_ack || wb_err) && !got_resp) begin
                    got_resp = 1'b1;
                    if (wb_err || (!cap_wr && wb_dat_r != pat(cap_idx))) begin
                        if (m_errs == 0) m_first = cap_adr;
                        m_errs++;
                    end
                end
            end
            if (!wb_cyc && cyc_p) begin
                // Dropped without a response while the test still runs: a watchdog expiry
                if (!got_resp && (busy || done)) begin
                    chk("timeout_len", cyc_len, To);
                    if (m_errs == 0) m_first = cap_adr;
                    m_errs++;
                end
                tx_n++;
            end
            if (done && !done_p) begin
                chk("run_tx_count", tx_n, 2*Nw);
                chk("model_err_count", err_count, m_errs);
                chk("model_first_err", first_err, m_first);
                chk("model_pass", pass, m_errs == 0);
                if (lit_on) begin
                    chk("lit_err_count", err_count, lit_errs);
                    chk("lit_first_err", first_err, lit_first);
                    chk("lit_pass", pass, lit_errs == 0);
                end
            end
            init_pp = init_p; init_p = init_done;
            busy_p = busy; cyc_p = wb_cyc; done_p = done;
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) hung = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic set_lit(input int errs, input logic [29:0] first);
        lit_on = 1'b1; lit_errs = errs; lit_first = first;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Clean run; auto-start on init_done, a start pulse mid-run must be ignored
        set_lit(0, 30'h0);
        init_done = 1'b1;
        repeat (20) @(posedge clk);
        #1 pulse_start();
        wait_done();

        // Read data of word 5 corrupted
        f_flip[5] = 1'b1;
        set_lit(1, Base + 30'd5);
        pulse_start();
        wait_done();
        f_flip = '0;

        // Bus errors on reads of words 2 and 9
        f_rderr[2] = 1'b1; f_rderr[9] = 1'b1;
        set_lit(2, Base + 30'd2);
        pulse_start();
        wait_done();
        f_rderr = '0;

        // Write to word 3 never acked; word 3 still holds its pattern from earlier runs,
        // so only the timeout counts
        f_noack[3] = 1'b1;
        set_lit(1, Base + 30'd3);
        pulse_start();
        wait_done();
        f_noack = '0;

        // Clean rerun must replay the first run's address/data sequence
        cmp_seq = 1'b1;
        set_lit(0, 30'h0);
        pulse_start();
        wait_done();

        // init_done lost mid write phase, then restored
        pulse_start();
        n = 0;
        while (!(tx_n >= 5 && wb_cyc) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(tx_n >= 5 && wb_cyc)) hung = 1'b1;
        init_done = 1'b0;
        repeat (4) @(posedge clk);
        #1 init_done = 1'b1;
        wait_done();

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule
